// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, transmitting end of the IFU->IDU handshake.
// Reads 64-bit words from a synchronous SRAM (1-cycle latency) starting at a
// programmed PC and buffers them in a 2-entry FIFO toward IDU. It pre-decodes
// WFI, stops fetching after it, and halts until the next start pulse.
// Optional feature macro: IFU_PERF_CNT_EN (instruction transfer counter).
// Without it, ifu_ins_cnt is tied to zero.

`ifndef OP_RNG
`define OP_RNG 6:0
`endif
`ifndef WFI_OP_CODE
`define WFI_OP_CODE 7'b1110011
`endif

module ifu_fetch #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   output logic          ifu_imem_en,
   output logic [AW-1:0] ifu_imem_addr,
   input  logic [63:0]   imem_ifu_data,
   output logic          ifu_idu_vld,
   output logic [63:0]   ifu_idu_ins,
   input  logic          idu_ifu_rdy,
   input  logic          idu_ifu_wfi,
   output logic          ifu_busy,
   output logic          ifu_halt,
   output logic [31:0]   ifu_ins_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [1:0]        state_r, state_nxt_s;
   logic [AW-1:0]     pc_r, pc_nxt_s;
   logic [AW-1:0]     rd_addr_r;
   logic              rd_pend_r;
   logic [1:0][63:0]  fifo_mem_r;
   logic              wr_ptr_r, rd_ptr_r;
   logic [1:0]        fifo_cnt_r, fifo_cnt_nxt_s;
   logic              pop_s, push_s, rsp_wfi_s, issue_s, start_ok_s;
   logic [2:0]        credit_s;

   // Pre-decode: does this word carry the WFI opcode?
   function automatic logic is_wfi(input logic [63:0] ins);
      return (ins[`OP_RNG] == `WFI_OP_CODE);
   endfunction

   // Handshake, response acceptance and read-credit decode
   always_comb begin
      pop_s          = (fifo_cnt_r != 2'd0) & idu_ifu_rdy;
      // Responses are only kept in FETCH; in DRAIN the read issued alongside
      // the returning WFI is dropped so nothing past the WFI reaches IDU.
      push_s         = rd_pend_r & (state_r == ST_FETCH);
      rsp_wfi_s      = push_s & is_wfi(imem_ifu_data);
      // A read may only go out if its result is guaranteed a FIFO slot next cycle.
      credit_s       = {1'b0, fifo_cnt_r} + {2'b00, rd_pend_r} - {2'b00, pop_s};
      issue_s        = (state_r == ST_FETCH) & (credit_s < 3'd2);
      start_ok_s     = start & ~idu_ifu_wfi & ((state_r == ST_IDLE) | (state_r == ST_HALT));
      fifo_cnt_nxt_s = fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
   end

   // Next-state selection for the fetch control FSM
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_HALT: begin
            if (start_ok_s) state_nxt_s = ST_FETCH;
            else            state_nxt_s = state_r;
         end
         ST_FETCH: begin
            if (rsp_wfi_s) state_nxt_s = ST_DRAIN;
            else           state_nxt_s = ST_FETCH;
         end
         ST_DRAIN: begin
            if (fifo_cnt_nxt_s == 2'd0) state_nxt_s = ST_HALT;
            else                        state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next PC: load on start, rewind past a returning WFI, else step per read
   always_comb begin
      pc_nxt_s = pc_r;
      if (start_ok_s)     pc_nxt_s = start_pc;
      else if (rsp_wfi_s) pc_nxt_s = rd_addr_r + PC_ONE;
      else if (issue_s)   pc_nxt_s = pc_r + PC_ONE;
      else                pc_nxt_s = pc_r;
   end

   // Control state, PC and outstanding-read tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pc_r      <= {AW{1'b0}};
         rd_addr_r <= {AW{1'b0}};
         rd_pend_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pc_r      <= pc_nxt_s;
         rd_pend_r <= issue_s;
         if (issue_s) rd_addr_r <= pc_r;
         else         rd_addr_r <= rd_addr_r;
      end
   end

   // Two-entry instruction FIFO; the head entry is untouched while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem_r <= {2{64'd0}};
         wr_ptr_r   <= 1'b0;
         rd_ptr_r   <= 1'b0;
         fifo_cnt_r <= 2'd0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= imem_ifu_data;
            wr_ptr_r             <= ~wr_ptr_r;
         end
         if (pop_s) rd_ptr_r <= ~rd_ptr_r;
         fifo_cnt_r <= fifo_cnt_nxt_s;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] ins_cnt_r;

   // Count IDU transfers since reset or the last accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          ins_cnt_r <= 32'd0;
      else if (start_ok_s) ins_cnt_r <= 32'd0;
      else if (pop_s)      ins_cnt_r <= ins_cnt_r + 32'd1;
      else                 ins_cnt_r <= ins_cnt_r;
   end

   assign ifu_ins_cnt = ins_cnt_r;
`else
   assign ifu_ins_cnt = 32'd0;
`endif

   assign ifu_imem_en   = issue_s;
   assign ifu_imem_addr = pc_r;
   assign ifu_idu_vld   = (fifo_cnt_r != 2'd0);
   assign ifu_idu_ins   = fifo_mem_r[rd_ptr_r];
   assign ifu_busy      = (state_r == ST_FETCH) | (state_r == ST_DRAIN);
   assign ifu_halt      = (state_r == ST_HALT);

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch. A behavioural SRAM feeds the
// DUT; expected IDU traffic is the program walked from start_pc up to and
// including the first WFI, and reads must appear in wrapped address order.

`ifndef OP_RNG
`define OP_RNG 6:0
`endif
`ifndef WFI_OP_CODE
`define WFI_OP_CODE 7'b1110011
`endif

module tb_ifu_fetch;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_pc;
   logic          ifu_imem_en;
   logic [AW-1:0] ifu_imem_addr;
   logic [63:0]   imem_ifu_data;
   logic          ifu_idu_vld;
   logic [63:0]   ifu_idu_ins;
   logic          idu_ifu_rdy;
   logic          idu_ifu_wfi;
   logic          ifu_busy;
   logic          ifu_halt;
   logic [31:0]   ifu_ins_cnt;

   logic [63:0] imem [0:(1<<AW)-1];
   int errors = 0;
   int checks = 0;
   int rd_cyc_q[$];
   int xfer_cyc_q[$];

   ifu_fetch #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
      .ifu_imem_en(ifu_imem_en), .ifu_imem_addr(ifu_imem_addr),
      .imem_ifu_data(imem_ifu_data), .ifu_idu_vld(ifu_idu_vld),
      .ifu_idu_ins(ifu_idu_ins), .idu_ifu_rdy(idu_ifu_rdy),
      .idu_ifu_wfi(idu_ifu_wfi), .ifu_busy(ifu_busy), .ifu_halt(ifu_halt),
      .ifu_ins_cnt(ifu_ins_cnt)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM: data one cycle after the enable
   always @(posedge clk) begin
      if (ifu_imem_en) imem_ifu_data <= imem[ifu_imem_addr];
   end

   function automatic logic [63:0] rand_word(input bit wfi);
      logic [63:0] w;
      w = {$urandom, $urandom};
      if (wfi) w[`OP_RNG] = `WFI_OP_CODE;
      else while (w[`OP_RNG] == `WFI_OP_CODE) w = {$urandom, $urandom};
      return w;
   endfunction

   // Start a program and watch it to HALT. mode: 0 rdy=1, 1 random, 2 toggle,
   // 3 rdy=0 for a few cycles after the first valid.
   task automatic run_prog(input logic [AW-1:0] spc, input int mode, input int budget,
                           output int n_xfer);
      logic [63:0] exp_q[$];
      logic [63:0] w, held_ins;
      logic [AW-1:0] a, exp_rd;
      bit hold_prev, seen_busy, done, stall_on;
      int reads, nprog, stall_left, exp_cnt;
      exp_q = {};
      a = spc;
      for (int i = 0; i < (1 << AW); i++) begin
         w = imem[a];
         exp_q.push_back(w);
         a++;
         if (w[`OP_RNG] == `WFI_OP_CODE) break;
      end
      nprog = exp_q.size();
      exp_rd = spc; reads = 0; n_xfer = 0; hold_prev = 1'b0; held_ins = 64'd0;
      seen_busy = 1'b0; done = 1'b0; stall_on = 1'b0; stall_left = 0;
      rd_cyc_q = {}; xfer_cyc_q = {};
      @(posedge clk); #1;
      start = 1'b1; start_pc = spc;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         if (cyc != 0) begin
            @(posedge clk); #1;
            start = 1'b0;
         end
         case (mode)
            0: idu_ifu_rdy = 1'b1;
            1: idu_ifu_rdy = 1'($urandom_range(0, 1));
            2: idu_ifu_rdy = ~idu_ifu_rdy;
            default: begin
               if (!stall_on) idu_ifu_rdy = 1'b0;
               else if (stall_left > 0) begin
                  idu_ifu_rdy = 1'b0;
                  stall_left--;
               end else idu_ifu_rdy = 1'b1;
            end
         endcase
         @(negedge clk);
         if (ifu_imem_en) begin
            checks++;
            if (ifu_imem_addr !== exp_rd) begin
               errors++;
               $display("FAIL rd_order: addr=%h expected=%h", ifu_imem_addr, exp_rd);
            end
            exp_rd++;
            reads++;
            rd_cyc_q.push_back(cyc);
         end
         if (hold_prev) begin
            checks++;
            if (ifu_idu_vld !== 1'b1 || ifu_idu_ins !== held_ins) begin
               errors++;
               $display("FAIL head_stable: vld=%b ins=%h expected vld=1 ins=%h",
                        ifu_idu_vld, ifu_idu_ins, held_ins);
            end
         end
         if (ifu_idu_vld === 1'b1 && idu_ifu_rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL xfer_extra: ins=%h expected no transfer", ifu_idu_ins);
            end else begin
               if (ifu_idu_ins !== exp_q[0]) begin
                  errors++;
                  $display("FAIL xfer_data: ins=%h expected=%h", ifu_idu_ins, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            n_xfer++;
            xfer_cyc_q.push_back(cyc);
         end
         checks++;
         if (reads - n_xfer > 3) begin
            errors++;
            $display("FAIL credit: reads_minus_xfers=%0d expected<=3", reads - n_xfer);
         end
         hold_prev = ifu_idu_vld & ~idu_ifu_rdy;
         held_ins  = ifu_idu_ins;
         if (ifu_idu_vld === 1'b1 && !stall_on) begin
            stall_on = 1'b1;
            stall_left = 5;
         end
         if (ifu_busy === 1'b1) seen_busy = 1'b1;
         if (seen_busy && ifu_halt === 1'b1) done = 1'b1;
      end
      start = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL halt_timeout: halt=%b expected=1 within %0d cycles", ifu_halt, budget);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL xfer_missing: remaining=%0d expected=0", exp_q.size());
      end
      checks++;
      if (reads > nprog + 1) begin
         errors++;
         $display("FAIL read_count: reads=%0d expected<=%0d", reads, nprog + 1);
      end
      checks++;
      if (ifu_idu_vld !== 1'b0 || ifu_busy !== 1'b0) begin
         errors++;
         $display("FAIL halt_state: vld=%b busy=%b expected 0 0", ifu_idu_vld, ifu_busy);
      end
`ifdef IFU_PERF_CNT_EN
      exp_cnt = nprog;
`else
      exp_cnt = 0;
`endif
      checks++;
      if (ifu_ins_cnt !== 32'(exp_cnt)) begin
         errors++;
         $display("FAIL ins_cnt: cnt=%0d expected=%0d", ifu_ins_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start_pc = '0; idu_ifu_rdy = 1'b0; idu_ifu_wfi = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ifu_imem_en, ifu_idu_vld, ifu_busy, ifu_halt} !== 4'b0000 || ifu_idu_ins !== 64'd0 ||
          ifu_ins_cnt !== 32'd0 || ifu_imem_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_state: en=%b vld=%b busy=%b halt=%b ins=%h cnt=%0d addr=%h expected all 0",
                  ifu_imem_en, ifu_idu_vld, ifu_busy, ifu_halt, ifu_idu_ins, ifu_ins_cnt, ifu_imem_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int n;
      for (int i = 0; i < 3; i++) imem[10'h010 + i] = rand_word(1'b0);
      imem[10'h013] = rand_word(1'b1);
      run_prog(10'h010, 0, 60, n);
      checks++;
      if (rd_cyc_q.size() < 4) begin
         errors++;
         $display("FAIL basic_reads: reads=%0d expected>=4", rd_cyc_q.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (rd_cyc_q[i] != rd_cyc_q[0] + i) begin
               errors++;
               $display("FAIL basic_rd_back2back: cycle=%0d expected=%0d", rd_cyc_q[i], rd_cyc_q[0] + i);
            end
         end
      end
      checks++;
      if (xfer_cyc_q.size() != 4) begin
         errors++;
         $display("FAIL basic_xfers: xfers=%0d expected=4", xfer_cyc_q.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (xfer_cyc_q[i] != xfer_cyc_q[0] + i) begin
               errors++;
               $display("FAIL basic_vld_back2back: cycle=%0d expected=%0d", xfer_cyc_q[i], xfer_cyc_q[0] + i);
            end
         end
      end
   endtask

   task automatic test_stall();
      int n, early;
      for (int i = 0; i < 3; i++) imem[10'h010 + i] = rand_word(1'b0);
      imem[10'h013] = rand_word(1'b1);
      run_prog(10'h010, 3, 80, n);
      early = 0;
      if (xfer_cyc_q.size() > 0)
         foreach (rd_cyc_q[i]) if (rd_cyc_q[i] < xfer_cyc_q[0]) early++;
      checks++;
      if (xfer_cyc_q.size() == 0 || early > 3) begin
         errors++;
         $display("FAIL stall_reads: reads_before_first_xfer=%0d expected<=3 (xfers=%0d)",
                  early, xfer_cyc_q.size());
      end
   endtask

   task automatic test_wrap();
      int n;
      imem[10'h3FF] = rand_word(1'b0);
      imem[10'h000] = rand_word(1'b1);
      run_prog(10'h3FF, 1, 80, n);
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL wrap_xfers: xfers=%0d expected=2", n);
      end
   endtask

   task automatic test_wfi_hold();
      int n;
      @(posedge clk); #1;
      idu_ifu_wfi = 1'b1; start = 1'b1; start_pc = 10'h020;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (ifu_halt !== 1'b1 || ifu_imem_en !== 1'b0) begin
            errors++;
            $display("FAIL wfi_start_ignored: halt=%b en=%b expected 1 0", ifu_halt, ifu_imem_en);
         end
      end
      @(posedge clk); #1;
      idu_ifu_wfi = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (ifu_halt !== 1'b1 || ifu_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_not_queued: halt=%b busy=%b expected 1 0", ifu_halt, ifu_busy);
         end
      end
      imem[10'h020] = rand_word(1'b0);
      imem[10'h021] = rand_word(1'b0);
      imem[10'h022] = rand_word(1'b1);
      run_prog(10'h020, 1, 80, n);
   endtask

   task automatic test_toggle();
      int n;
      for (int i = 0; i < 8; i++) imem[10'h200 + i] = rand_word(1'b0);
      imem[10'h208] = rand_word(1'b1);
      run_prog(10'h200, 2, 120, n);
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL toggle_xfers: xfers=%0d expected=9", n);
      end
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 8; i++) imem[10'h100 + i] = rand_word(1'b0);
      @(posedge clk); #1;
      start = 1'b1; start_pc = 10'h100; idu_ifu_rdy = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ifu_idu_vld !== 1'b1 || ifu_busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: vld=%b busy=%b expected 1 1", ifu_idu_vld, ifu_busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({ifu_imem_en, ifu_idu_vld, ifu_busy, ifu_halt} !== 4'b0000 ||
          ifu_imem_addr !== 10'd0 || ifu_ins_cnt !== 32'd0) begin
         errors++;
         $display("FAIL midreset_state: en=%b vld=%b busy=%b halt=%b addr=%h cnt=%0d expected all 0",
                  ifu_imem_en, ifu_idu_vld, ifu_busy, ifu_halt, ifu_imem_addr, ifu_ins_cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; idu_ifu_rdy = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (ifu_idu_vld !== 1'b0 || ifu_imem_en !== 1'b0 || ifu_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: vld=%b en=%b busy=%b expected 0 0 0",
                     ifu_idu_vld, ifu_imem_en, ifu_busy);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      int n, len;
      logic [AW-1:0] spc, a;
      for (int t = 0; t < 6; t++) begin
         spc = AW'($urandom_range(0, (1 << AW) - 1));
         len = $urandom_range(1, 7);
         a = spc;
         for (int i = 0; i < len - 1; i++) begin
            imem[a] = rand_word(1'b0);
            a++;
         end
         imem[a] = rand_word(1'b1);
         run_prog(spc, 1, 150, n);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) imem[i] = rand_word(1'b0);
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_wfi_hold();
      test_toggle();
      test_midreset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
